// File: rtl/vproc_elem_red.sv
// Vector element reduction: folds LANES elements per beat into one scalar result.
// Define VPROC_ELEM_RED_MASKED_EN to let in_mask_i/in_masked_i gate lane contribution.
module vproc_elem_red #(
    parameter int LANES       = 4,
    parameter bit BUF_RESULTS = 1'b1
) (
    input  logic                clk_i,
    input  logic                sync_rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                in_first_i,
    input  logic                in_last_i,
    input  logic [2:0]          in_op_i,
    input  logic [1:0]          in_eew_i,
    input  logic [31:0]         in_init_i,
    input  logic [LANES*32-1:0] in_data_i,
    input  logic [LANES-1:0]    in_active_i,
    input  logic [LANES-1:0]    in_mask_i,
    input  logic                in_masked_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [31:0]         out_res_o,
    output logic                out_empty_o,
    output logic [15:0]         out_count_o,
    output logic [1:0]          dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never waits on ready, and payloads are held until the transfer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [2:0] OP_SUM  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_MINU = 3'd4;
    localparam logic [2:0] OP_MIN  = 3'd5;
    localparam logic [2:0] OP_MAXU = 3'd6;
    localparam logic [2:0] OP_MAX  = 3'd7;

    function automatic logic [31:0] eew_mask(input logic [1:0] eew);
        case (eew)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Operands are widened to 32 bits so one comparator serves every element width.
    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] eew,
                                           input logic sgn);
        case (eew)
            2'd0:    return sgn ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
            2'd1:    return sgn ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [31:0] identity(input logic [2:0] op);
        case (op)
            OP_AND, OP_MINU: return 32'hFFFF_FFFF;
            OP_MIN:          return 32'h7FFF_FFFF;
            OP_MAX:          return 32'h8000_0000;
            default:         return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] combine(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            OP_SUM:  return a + b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_MINU: return (a < b) ? a : b;
            OP_MIN:  return ($signed(a) < $signed(b)) ? a : b;
            OP_MAXU: return (a > b) ? a : b;
            default: return ($signed(a) > $signed(b)) ? a : b;
        endcase
    endfunction

    state_e      state_q;
    logic [2:0]  op_q;
    logic [1:0]  eew_q;
    logic [31:0] acc_q;
    logic [15:0] cnt_q;

    logic [LANES-1:0] contrib;
    logic             in_fire;
    logic             take;
    logic             done_beat;
    logic [2:0]       sel_op;
    logic [1:0]       sel_eew;
    logic             sel_sgn;
    logic [31:0]      seed_res;
    logic [15:0]      seed_cnt;
    logic [4:0]       lane_pop;
    logic [31:0]      tree [2*LANES];
    logic [31:0]      fold_res;
    logic [16:0]      cnt_sum;
    logic [15:0]      fold_cnt;

`ifdef VPROC_ELEM_RED_MASKED_EN
    assign contrib = in_active_i & (in_mask_i | {LANES{~in_masked_i}});
`else
    logic unused_mask;
    assign contrib     = in_active_i;
    assign unused_mask = ^{in_mask_i, in_masked_i};
`endif

    assign in_ready_o = (state_q != DONE);
    assign in_fire    = in_valid_i & in_ready_o;
    // Non-first beats outside a reduction are swallowed without effect.
    assign take       = in_fire & (in_first_i | (state_q == ACCUM));
    assign done_beat  = take & in_last_i;

    always_comb begin
        sel_op   = in_first_i ? in_op_i : op_q;
        sel_eew  = in_first_i ? in_eew_i : eew_q;
        sel_sgn  = (sel_op == OP_MIN) || (sel_op == OP_MAX);
        seed_res = in_first_i ? (in_init_i & eew_mask(in_eew_i)) : acc_q;
        seed_cnt = in_first_i ? 16'd0 : cnt_q;
        lane_pop = '0;
        for (int n = 0; n < 2 * LANES; n++) begin
            tree[n] = '0;
        end
        // Leaves sit at LANES..2*LANES-1; node n combines children 2n and 2n+1.
        for (int k = 0; k < LANES; k++) begin
            lane_pop        = lane_pop + {4'd0, contrib[k]};
            tree[LANES + k] = contrib[k] ? extend(in_data_i[32*k +: 32], sel_eew, sel_sgn)
                                         : identity(sel_op);
        end
        for (int n = LANES - 1; n >= 1; n--) begin
            tree[n] = combine(sel_op, tree[2*n], tree[2*n+1]);
        end
        fold_res = combine(sel_op, extend(seed_res, sel_eew, sel_sgn), tree[1])
                   & eew_mask(sel_eew);
        cnt_sum  = {1'b0, seed_cnt} + {12'd0, lane_pop};
        fold_cnt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            eew_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (take) begin
                        acc_q <= fold_res;
                        cnt_q <= fold_cnt;
                        if (in_first_i) begin
                            op_q  <= in_op_i;
                            eew_q <= in_eew_i;
                        end
                        if (!in_last_i) begin
                            state_q <= ACCUM;
                        end else if (!BUF_RESULTS && out_ready_i) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The accumulator doubles as the result register; it is frozen while in DONE.
    if (BUF_RESULTS) begin : g_buf_out
        assign out_valid_o = (state_q == DONE);
        assign out_res_o   = acc_q;
        assign out_count_o = cnt_q;
    end else begin : g_comb_out
        assign out_valid_o = (state_q == DONE) | done_beat;
        assign out_res_o   = done_beat ? fold_res : acc_q;
        assign out_count_o = done_beat ? fold_cnt : cnt_q;
    end

    assign out_empty_o = (out_count_o == 16'd0);
    assign dbg_state_o = state_q;

endmodule
